// File: rtl/arvi_fetch_pkg.sv
// Shared types for the instruction-fetch front end.
//   fetch_entry_t : one queue entry handed to decode {pc, inst, ex}
//   fetch_state_t : fetch request FSM state
//   FETCH_XLEN    : width of the pc/inst fields carried in a queue entry
// `PC_RESET supplies the default reset fetch address when the build does not set it.
`ifndef PC_RESET
`define PC_RESET 32'h0000_0000
`endif

package arvi_fetch_pkg;

  localparam int FETCH_XLEN = 32;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] inst;
    logic                  ex;
  } fetch_entry_t;

  typedef enum logic {F_IDLE, F_REQ} fetch_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered head output.
//   clk, rst       : clock, synchronous active-high reset
//   push/push_data : enqueue (accepted when not full, or full with a pop)
//   pop            : dequeue head (ignored when empty)
//   flush          : clear all entries; wins over push and pop
//   head           : current head entry; holds its last value when empty
//   full/empty/count
module sync_fifo #(
  parameter type T     = logic,
  parameter int  DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  T                           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output T                           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  T              mem_q [DEPTH];
  T              head_q, head_d;
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  always_comb begin
    do_pop  = pop && (cnt_q != '0) && !flush;
    do_push = push && ((cnt_q != CW'(DEPTH)) || do_pop) && !flush;
    rd_d    = rd_q + AW'(do_pop);
    wr_d    = wr_q + AW'(do_push);
    cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
    head_d  = head_q;
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else if ((cnt_q - CW'(do_pop)) == '0) begin
      // Nothing left behind the pop: the new head (if any) is the incoming word.
      if (do_push) head_d = push_data;
    end else begin
      head_d = mem_q[rd_d];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      head_q <= '0;
    end else begin
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
      head_q <= head_d;
    end
  end

  assign head  = head_q;
  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, prefetches over the
// req/ready memory port into a DEPTH-entry queue, and presents the queue
// head to decode with a valid/ready handshake. Redirects flush and restart.
//   i_clk, i_rst              : clock, synchronous active-high reset
//   o_DataReq, o_IM_Addr      : fetch request / address (held until i_MemReady)
//   i_MemReady, i_IM_Instr    : request completion and fetched word
//   i_redirect, i_redirect_pc : flush and restart fetch at a new PC
//   o_valid, o_pc, o_inst,
//   o_ex_inst_addr, i_ready   : decode-side head entry and handshake
module fetch_unit
  import arvi_fetch_pkg::*;
#(
  parameter int              XLEN     = FETCH_XLEN,
  parameter logic [XLEN-1:0] PC_RESET = `PC_RESET,
  parameter int              DEPTH    = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  output logic            o_DataReq,
  output logic [XLEN-1:0] o_IM_Addr,
  input  logic            i_MemReady,
  input  logic [XLEN-1:0] i_IM_Instr,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_valid,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_inst,
  output logic            o_ex_inst_addr,
  input  logic            i_ready
);

  localparam int            CW      = $clog2(DEPTH+1);
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;   // address of the request on the bus
  logic            stale_q, stale_d;         // in-flight request predates a redirect
  logic            mis_q, mis_d;             // misaligned-target entry still to enqueue
  logic            halt_q, halt_d;           // fetching stopped until next redirect

  logic            push, pop, flush, mem_done, misaligned;
  logic            fifo_full, fifo_empty;
  fetch_entry_t    push_data, head;
  logic [CW-1:0]   count;
  logic [CW:0]     cnt_nxt;

  sync_fifo #(.T(fetch_entry_t), .DEPTH(DEPTH)) u_fifo (
    .clk       (i_clk),
    .rst       (i_rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (flush),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (count)
  );

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    stale_d    = stale_q;
    mis_d      = mis_q;
    halt_d     = halt_q;
    flush      = i_redirect;
    pop        = !fifo_empty && i_ready && !i_redirect;
    push       = 1'b0;
    push_data  = '0;
    mem_done   = (state_q == F_REQ) && i_MemReady;
    misaligned = (i_redirect_pc[1:0] != 2'b00);

    if (mem_done) begin
      stale_d = 1'b0;
      if (!stale_q) begin
        push       = !fifo_full || pop;
        push_data  = '{pc: fetch_pc_q, inst: i_IM_Instr, ex: 1'b0};
        fetch_pc_d = fetch_pc_q + XLEN'(4);
      end
    end

    // Exception entry waits until the flushed queue is drained of stale traffic.
    if (mis_q && !stale_q && fifo_empty && state_q == F_IDLE) begin
      push      = 1'b1;
      push_data = '{pc: fetch_pc_q, inst: '0, ex: 1'b1};
      mis_d     = 1'b0;
    end

    // Occupancy after this edge; a new request only issues into a free slot.
    cnt_nxt = {1'b0, count} + (CW+1)'(push) - (CW+1)'(pop);

    case (state_q)
      F_IDLE: begin
        if (!halt_q && cnt_nxt < DEPTH_C) begin
          state_d    = F_REQ;
          req_addr_d = fetch_pc_q;
        end
      end
      F_REQ: begin
        if (i_MemReady) begin
          if (!halt_q && cnt_nxt < DEPTH_C) req_addr_d = fetch_pc_d;
          else                              state_d    = F_IDLE;
        end
      end
      default: state_d = F_IDLE;
    endcase

    if (i_redirect) begin
      fetch_pc_d = i_redirect_pc;
      mis_d      = misaligned;
      halt_d     = misaligned;
      if (state_q == F_REQ && !i_MemReady) begin
        // Keep the bus request alive; its data is dropped on completion.
        stale_d    = 1'b1;
        state_d    = F_REQ;
        req_addr_d = req_addr_q;
      end else begin
        stale_d = 1'b0;
        if (misaligned) begin
          state_d    = F_IDLE;
          req_addr_d = req_addr_q;
        end else begin
          state_d    = F_REQ;
          req_addr_d = i_redirect_pc;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= F_IDLE;
      fetch_pc_q <= PC_RESET;
      req_addr_q <= PC_RESET;
      stale_q    <= 1'b0;
      mis_q      <= 1'b0;
      halt_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      stale_q    <= stale_d;
      mis_q      <= mis_d;
      halt_q     <= halt_d;
    end
  end

  assign o_DataReq      = (state_q == F_REQ);
  assign o_IM_Addr      = req_addr_q;
  assign o_valid        = !fifo_empty;
  assign o_pc           = head.pc;
  assign o_inst         = head.inst;
  assign o_ex_inst_addr = head.ex;

endmodule
